// File: rtl/mul_ctrl.sv
// RV32M multiply sequencer: sign handling, multiplier handshake, one-entry product cache.
// Sits between execute-stage issue logic and a 32x32 unsigned shift-add multiplier.
module mul_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [1:0]        funct3_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [XLEN-1:0]   result_o,
    output logic [4:0]        rd_addr_o,
    output logic              mul_req_o,
    output logic [XLEN-1:0]   mul_a_o,
    output logic [XLEN-1:0]   mul_b_o,
    input  logic              mul_ready_i,
    input  logic [2*XLEN-1:0] mul_result_i
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;

    localparam logic [1:0] FnMul    = 2'd0;
    localparam logic [1:0] FnMulh   = 2'd1;
    localparam logic [1:0] FnMulhsu = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        funct3_q;
    logic [4:0]        rd_q;
    logic              neg_p_q;
    logic [2*XLEN-1:0] prod_q;
    logic              cache_valid_q;
    logic [XLEN-1:0]   key_a_q, key_b_q;
    logic [2*XLEN-1:0] cache_prod_q;

    logic              neg_a, neg_b, hit, accept;
    logic [XLEN-1:0]   mag_a, mag_b, fix_word;
    logic [2*XLEN-1:0] prod_fix;

    // MUL leaves both negate flags clear: the low word does not depend on operand signs.
    assign neg_a  = rs1_i[XLEN-1] & ((funct3_i == FnMulh) | (funct3_i == FnMulhsu));
    assign neg_b  = rs2_i[XLEN-1] & (funct3_i == FnMulh);
    assign mag_a  = neg_a ? (~rs1_i + XLEN'(1)) : rs1_i;
    assign mag_b  = neg_b ? (~rs2_i + XLEN'(1)) : rs2_i;
    assign hit    = cache_valid_q && (mag_a == key_a_q) && (mag_b == key_b_q);
    assign accept = (state_q == StIdle) && valid_i && !flush_i;

    assign prod_fix = neg_p_q ? (~prod_q + (2*XLEN)'(1)) : prod_q;
    assign fix_word = (funct3_q == FnMul) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

    assign busy_o = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (valid_i) state_d = hit ? StFix : StWait;
                StWait:  if (mul_ready_i) state_d = StFix;
                StFix:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= StIdle;
            funct3_q      <= '0;
            rd_q          <= '0;
            neg_p_q       <= 1'b0;
            prod_q        <= '0;
            cache_valid_q <= 1'b0;
            key_a_q       <= '0;
            key_b_q       <= '0;
            cache_prod_q  <= '0;
            done_o        <= 1'b0;
            result_o      <= '0;
            rd_addr_o     <= '0;
            mul_req_o     <= 1'b0;
            mul_a_o       <= '0;
            mul_b_o       <= '0;
        end else begin
            state_q <= state_d;
            done_o  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        funct3_q <= funct3_i;
                        rd_q     <= rd_addr_i;
                        neg_p_q  <= neg_a ^ neg_b;
                        if (hit) begin
                            prod_q <= cache_prod_q;
                        end else begin
                            mul_a_o   <= mag_a;
                            mul_b_o   <= mag_b;
                            mul_req_o <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    // A flush on the ready cycle drops the product without touching the cache.
                    if (flush_i) begin
                        mul_req_o <= 1'b0;
                    end else if (mul_ready_i) begin
                        mul_req_o     <= 1'b0;
                        prod_q        <= mul_result_i;
                        cache_valid_q <= 1'b1;
                        key_a_q       <= mul_a_o;
                        key_b_q       <= mul_b_o;
                        cache_prod_q  <= mul_result_i;
                    end
                end
                StFix: begin
                    if (!flush_i) begin
                        done_o    <= 1'b1;
                        result_o  <= fix_word;
                        rd_addr_o <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: arithmetic reference model, per-cycle compare,
// behavioural multiplier stub with the team latencies, directed and random stimulus.
module tb_mul_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [1:0]  funct3_i = 2'd0;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o, done_o, mul_req_o;
    logic [31:0] result_o, mul_a_o, mul_b_o;
    logic [4:0]  rd_addr_o;
    logic        mul_ready_i = 1'b0;
    logic [63:0] mul_result_i = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: 0 free, 1 waiting on multiplier, 2 result due at m_done_at
    int          m_phase = 0;
    int          m_done_at = 0;
    logic [31:0] m_ma, m_mb, m_exp_res;
    logic [4:0]  m_exp_rd;
    logic [31:0] m_res = '0;
    logic [4:0]  m_rd = '0;
    bit          c_valid = 0;
    logic [31:0] c_a, c_b;

    // Multiplier stub
    bit mb_active = 0, mb_need_low = 0, mb_fired = 0;
    int mb_cnt = 0;

    always #5 clk_i = ~clk_i;

    mul_ctrl #(.XLEN(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .funct3_i     (funct3_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .rd_addr_i    (rd_addr_i),
        .flush_i      (flush_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .result_o     (result_o),
        .rd_addr_o    (rd_addr_o),
        .mul_req_o    (mul_req_o),
        .mul_a_o      (mul_a_o),
        .mul_b_o      (mul_b_o),
        .mul_ready_i  (mul_ready_i),
        .mul_result_i (mul_result_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            2'd1:    p = sa * sb;
            2'd2:    p = sa * ub;
            default: p = ua * ub;
        endcase
        return (f == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] x, input bit sgn);
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_res = '0;
        m_rd = '0;
        c_valid = 0;
        mb_active = 0;
        mb_need_low = 0;
        mb_fired = 0;
        mul_ready_i = 1'b0;
    endtask

    task automatic tick();
        bit s_valid, s_flush, s_ready, s_rst, exp_done;
        logic [1:0] s_f;
        logic [31:0] s_a, s_b;
        logic [4:0] s_rd;
        int start_phase;
        s_valid = valid_i; s_flush = flush_i; s_ready = mul_ready_i; s_rst = rst_i;
        s_f = funct3_i; s_a = rs1_i; s_b = rs2_i; s_rd = rd_addr_i;
        @(posedge clk_i);
        #1;
        cyc++;
        if (s_rst && rst_i) begin
            exp_done = 0;
            start_phase = m_phase;
            if (m_phase != 0 && s_flush) begin
                m_phase = 0;
            end else if (m_phase == 1 && s_ready) begin
                c_valid = 1; c_a = m_ma; c_b = m_mb;
                m_phase = 2; m_done_at = cyc + 1;
            end else if (m_phase == 2 && cyc == m_done_at) begin
                exp_done = 1; m_res = m_exp_res; m_rd = m_exp_rd;
                m_phase = 0;
            end
            if (start_phase == 0 && s_valid && !s_flush) begin
                m_ma = mag(s_a, (s_f == 2'd1) || (s_f == 2'd2));
                m_mb = mag(s_b, s_f == 2'd1);
                m_exp_res = ref_result(s_f, s_a, s_b);
                m_exp_rd = s_rd;
                if (c_valid && m_ma == c_a && m_mb == c_b) begin
                    m_phase = 2; m_done_at = cyc + 1;
                end else begin
                    m_phase = 1;
                end
            end
            chk("done_o", done_o, exp_done);
            chk("busy_o", busy_o, m_phase != 0);
            chk("mul_req_o", mul_req_o, m_phase == 1);
            if (m_phase == 1) begin
                chk("mul_a_o", mul_a_o, m_ma);
                chk("mul_b_o", mul_b_o, m_mb);
            end
            chk("result_o", result_o, m_res);
            chk("rd_addr_o", rd_addr_o, m_rd);

            // Stub: zero operand answers 2 cycles after request appears, otherwise 34.
            if (mb_fired) begin
                mul_ready_i = 1'b0; mb_fired = 0; mb_active = 0; mb_need_low = 1;
            end
            if (mb_need_low && !mul_req_o) mb_need_low = 0;
            mul_result_i = {32'($urandom), 32'($urandom)};
            if (mb_active) begin
                if (!mul_req_o) begin
                    mb_active = 0;
                end else begin
                    mb_cnt--;
                    if (mb_cnt == 0) begin
                        mul_ready_i = 1'b1;
                        mul_result_i = {32'd0, mul_a_o} * {32'd0, mul_b_o};
                        mb_fired = 1;
                    end
                end
            end else if (!mb_need_low && mul_req_o) begin
                mb_active = 1;
                mb_cnt = (mul_a_o == 0 || mul_b_o == 0) ? 2 : 34;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat, output bit req_seen);
        int acc;
        bit got;
        for (int w = 0; w < 200 && busy_o; w++) tick();
        valid_i = 1'b1; funct3_i = f; rs1_i = a; rs2_i = b; rd_addr_i = rd;
        tick();
        acc = cyc;
        valid_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom;
        req_seen = mul_req_o;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (mul_req_o) req_seen = 1;
            if (done_o) begin
                got = 1;
                break;
            end
        end
        chk({name, "_done_seen"}, got, 1);
        if (got) begin
            chk({name, "_result"}, result_o, exp_res);
            chk({name, "_rd"}, rd_addr_o, rd);
            if (exp_lat > 0) chk({name, "_latency"}, cyc - acc, exp_lat);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0007;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit rq;
        model_reset();
        tick();
        tick();
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_req", mul_req_o, 0);
        chk("reset_result", result_o, 0);
        rst_i = 1'b1;
        tick();

        run_op("mul_7x6", 2'd0, 32'd7, 32'd6, 5'd1, 32'h0000_002A, 36, rq);
        run_op("mulhu_zero", 2'd3, 32'd0, 32'h1234_5678, 5'd2, 32'h0, 4, rq);
        run_op("mulh_m1", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0, 36, rq);
        run_op("mul_m1", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h1, 36, rq);
        run_op("mulhu_m1_hit", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 1, rq);
        chk("mulhu_m1_hit_noreq", rq, 0);
        run_op("mulhsu_m1", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, 36, rq);
        run_op("mulh_min", 2'd1, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000, 36, rq);
        run_op("mul_min_hit", 2'd0, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'h0, 1, rq);
        chk("mul_min_hit_noreq", rq, 0);
        run_op("mulhu_pair", 2'd3, 32'h0001_0000, 32'h0003_0003, 5'd9, 32'h0000_0003, 36, rq);
        run_op("mul_pair_hit", 2'd0, 32'h0001_0000, 32'h0003_0003, 5'd10, 32'h0003_0000, 1, rq);
        chk("mul_pair_hit_noreq", rq, 0);

        // Flush five cycles into WAIT, then reissue: must miss again.
        valid_i = 1'b1; funct3_i = 2'd3; rs1_i = 32'hDEAD_BEEF; rs2_i = 32'h0000_0FFF;
        rd_addr_i = 5'd11;
        tick();
        valid_i = 1'b0;
        repeat (4) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_req_low", mul_req_o, 0);
        chk("flush_busy_low", busy_o, 0);
        repeat (3) tick();
        run_op("flush_reissue", 2'd3, 32'hDEAD_BEEF, 32'h0000_0FFF, 5'd11,
               ref_result(2'd3, 32'hDEAD_BEEF, 32'h0000_0FFF), 36, rq);

        // Flush on the same cycle the multiplier answers.
        valid_i = 1'b1; funct3_i = 2'd1; rs1_i = 32'hFFFF_0000; rs2_i = 32'h0000_1234;
        rd_addr_i = 5'd12;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 60 && !mul_ready_i; i++) tick();
        chk("flush_ready_seen", mul_ready_i, 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_ready_req_low", mul_req_o, 0);
        repeat (3) tick();
        run_op("flush_ready_reissue", 2'd1, 32'hFFFF_0000, 32'h0000_1234, 5'd12,
               ref_result(2'd1, 32'hFFFF_0000, 32'h0000_1234), 36, rq);

        // Asynchronous reset in the middle of WAIT.
        valid_i = 1'b1; funct3_i = 2'd3; rs1_i = 32'h0001_0000; rs2_i = 32'h0003_0003;
        rd_addr_i = 5'd13;
        tick();
        valid_i = 1'b0;
        repeat (5) tick();
        #1;
        rst_i = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_req", mul_req_o, 0);
        chk("arst_a", mul_a_o, 0);
        chk("arst_b", mul_b_o, 0);
        chk("arst_result", result_o, 0);
        chk("arst_rd", rd_addr_o, 0);
        model_reset();
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        run_op("arst_reissue", 2'd3, 32'h0001_0000, 32'h0003_0003, 5'd13, 32'h0000_0003, 36, rq);

        // Random traffic; valid may arrive while busy and must then be ignored.
        for (int i = 0; i < 2500; i++) begin
            valid_i = ($urandom % 3) == 0;
            funct3_i = 2'($urandom);
            rs1_i = pick();
            rs2_i = pick();
            rd_addr_i = 5'($urandom);
            flush_i = ($urandom % 50) == 0;
            tick();
        end
        valid_i = 1'b0;
        flush_i = 1'b0;
        for (int i = 0; i < 60 && busy_o; i++) tick();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
